// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared definitions for the CPU phase sequencer:
// state encodings, default halt opcode and widths.
package cpu_seq_ctrl_pkg;

   localparam int PHASE_W = 3;
   localparam int WAIT_W = 8;
   localparam logic [3:0] HALT_OP_DEF = 4'hF;

   typedef enum logic [PHASE_W-1:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_FAULT  = 3'd6
   } state_t;

   function automatic logic is_busy(input state_t s);
      return s inside {S_FETCH, S_DECODE, S_EXEC, S_WB};
   endfunction

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Control/status bundle between the sequencer
// and the datapath units it drives.
interface cpu_seq_ctrl_if #(
   parameter int CNT_W = 16
);
   import cpu_seq_ctrl_pkg::*;

   logic             run;
   logic             step;
   logic             halt_req;
   logic             mem_ready;
   logic [3:0]       op_code;
   logic             en_ft;
   logic             en_dc;
   logic             en_ex;
   logic             en_wb;
   logic [PHASE_W-1:0] phase;
   logic             busy;
   logic             halted;
   logic             fault;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output run, step, halt_req,
      output mem_ready, op_code,
      input  en_ft, en_dc, en_ex, en_wb,
      input  phase, busy, halted, fault,
      input  instr_count
   );

   modport slave (
      input  run, step, halt_req,
      input  mem_ready, op_code,
      output en_ft, en_dc, en_ex, en_wb,
      output phase, busy, halted, fault,
      output instr_count
   );

endinterface

// File: rtl/cpu_seq_ctrl_fetch_wait_timer.sv
// Wait-state counter with limit compare; reusable
// for any memory port that stalls on a ready signal.
module cpu_seq_ctrl_fetch_wait_timer
   import cpu_seq_ctrl_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_clear,
   input  logic              i_inc,
   input  logic [WAIT_W-1:0] i_limit,
   output logic              o_expired
);

   logic [WAIT_W-1:0] r_cnt;
   logic [WAIT_W-1:0] w_last;

   assign w_last = i_limit - WAIT_W'(1);

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + WAIT_W'(1);
      end
   end

   // Expiry fires on the last stalled cycle, before the count wraps.
   assign o_expired = i_inc && (r_cnt == w_last);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multicycle fetch/decode/exec/writeback sequencer
// with wait states, single-step, halt and fault trap.
module cpu_seq_ctrl
   import cpu_seq_ctrl_pkg::*;
#(
   parameter int         MAX_WAIT = 8,
   parameter logic [3:0] HALT_OP  = HALT_OP_DEF,
   parameter int         CNT_W    = 16
) (
   input  logic         i_clk,
   input  logic         i_reset,
   cpu_seq_ctrl_if.slave bus
);

   state_t           r_state;
   logic             r_step_mode;
   logic             r_pend_halt;
   logic [CNT_W-1:0] r_count;

   logic w_in_fetch;
   logic w_clear;
   logic w_inc;
   logic w_expired;
   logic w_halt_op;
   logic w_stop;

   assign w_in_fetch = (r_state == S_FETCH);
   assign w_clear    = !w_in_fetch || bus.mem_ready;
   assign w_inc      = w_in_fetch && !bus.mem_ready;
   assign w_halt_op  = (bus.op_code == HALT_OP);
   assign w_stop     = r_pend_halt || bus.halt_req
                       || r_step_mode;

   cpu_seq_ctrl_fetch_wait_timer u_wait (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (w_clear),
      .i_inc     (w_inc),
      .i_limit   (WAIT_W'(MAX_WAIT)),
      .o_expired (w_expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_step_mode <= 1'b0;
         r_pend_halt <= 1'b0;
         r_count     <= '0;
      end else begin
         unique case (r_state)
            S_IDLE, S_HALT: begin
               if (bus.step) begin
                  r_state     <= S_FETCH;
                  r_step_mode <= 1'b1;
               end else if (bus.run) begin
                  r_state     <= S_FETCH;
                  r_step_mode <= 1'b0;
               end
            end
            S_FETCH: begin
               r_pend_halt <= r_pend_halt | bus.halt_req;
               if (bus.mem_ready) begin
                  r_state <= S_DECODE;
               end else if (w_expired) begin
                  r_state <= S_FAULT;
               end
            end
            S_DECODE: begin
               r_pend_halt <= r_pend_halt | bus.halt_req;
               r_state     <= S_EXEC;
            end
            S_EXEC: begin
               // Halt opcode retires here without a writeback.
               if (w_halt_op) begin
                  r_count     <= r_count + CNT_W'(1);
                  r_state     <= S_HALT;
                  r_pend_halt <= 1'b0;
                  r_step_mode <= 1'b0;
               end else begin
                  r_pend_halt <= r_pend_halt | bus.halt_req;
                  r_state     <= S_WB;
               end
            end
            S_WB: begin
               r_count <= r_count + CNT_W'(1);
               if (w_stop) begin
                  r_state     <= S_HALT;
                  r_pend_halt <= 1'b0;
                  r_step_mode <= 1'b0;
               end else begin
                  r_state <= S_FETCH;
               end
            end
            S_FAULT: begin
               r_state <= S_FAULT;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.en_ft  = w_in_fetch && bus.mem_ready;
   assign bus.en_dc  = (r_state == S_DECODE);
   assign bus.en_ex  = (r_state == S_EXEC) && !w_halt_op;
   assign bus.en_wb  = (r_state == S_WB);
   assign bus.phase  = r_state;
   assign bus.busy   = is_busy(r_state);
   assign bus.halted = (r_state == S_HALT);
   assign bus.fault  = (r_state == S_FAULT);
   assign bus.instr_count = r_count;

   a_onehot_en: assert property (
      @(posedge i_clk)
      $onehot0({bus.en_ft, bus.en_dc,
                bus.en_ex, bus.en_wb})
   );

endmodule
